// File: rtl/chs_thermostat_ctrl_pkg.sv
// Shared types, default parameter values and small arithmetic helpers for the
// thermostat controller and its speed ramp.
package chs_thermostat_ctrl_pkg;

    // State encoding is visible on the state output: IDLE=0, HEAT=1, COOL=2, DEAD=3.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHeat = 2'd1,
        StCool = 2'd2,
        StDead = 2'd3
    } chs_state_e;

    localparam int unsigned DefHyst    = 2;
    localparam int unsigned DefDwell   = 16;
    localparam int unsigned DefRampDiv = 4;
    localparam int unsigned DefStep    = 8;
    localparam int unsigned DefGainSh  = 3;

    // Unsigned absolute difference of two 8-bit values.
    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Left shift with saturation at 255.
    function automatic logic [7:0] sat_shl(input logic [7:0] v, input int unsigned sh);
        logic [15:0] w;
        w = {8'd0, v} << sh;
        return (w > 16'd255) ? 8'hff : w[7:0];
    endfunction

endpackage

// File: rtl/chs_thermostat_ctrl_if.sv
// Sensor/user-register side and cool/heat datapath side of the thermostat
// controller, bundled as one interface.
interface chs_thermostat_ctrl_if;

    logic       enable;
    logic [7:0] temp;
    logic       temp_vld;
    logic [7:0] setpoint;
    logic [7:0] speed;
    logic [7:0] chs_conf;
    logic [1:0] state;
    logic       sample_err;

    // Driver of samples and user settings.
    modport master (
        output enable, temp, temp_vld, setpoint,
        input  speed, chs_conf, state, sample_err
    );

    // The controller itself.
    modport slave (
        input  enable, temp, temp_vld, setpoint,
        output speed, chs_conf, state, sample_err
    );

endinterface

// File: rtl/chs_thermostat_ctrl_speed_ramp.sv
// Rate-limited fan speed: a free-running prescaler gates steps of STEP toward
// the target, landing exactly on the target without overshoot or wrap.
module chs_thermostat_ctrl_speed_ramp
    import chs_thermostat_ctrl_pkg::*;
#(
    parameter int unsigned RAMP_DIV = DefRampDiv,
    parameter int unsigned STEP     = DefStep
) (
    input  logic       clk,
    input  logic       arst,
    input  logic [7:0] target_i,
    output logic [7:0] speed_o
);

    localparam int unsigned    PW      = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PW-1:0]  PresMax = PW'(RAMP_DIV - 1);
    localparam logic [8:0]     Step9   = 9'(STEP);

    logic [PW-1:0] presc_q, presc_d;
    logic          wrap;
    logic [7:0]    speed_q, speed_d;
    logic [8:0]    up_sum;
    logic [8:0]    dn_diff;

    // Prescaler counts 0..RAMP_DIV-1 and flags the wrap cycle.
    always_comb begin
        wrap    = (presc_q == PresMax);
        presc_d = wrap ? '0 : presc_q + PW'(1);
    end

    // Step toward target on wrap; bit 8 of dn_diff flags an underflow.
    always_comb begin
        up_sum  = {1'b0, speed_q} + Step9;
        dn_diff = {1'b0, speed_q} - Step9;
        speed_d = speed_q;
        if (wrap) begin
            if (target_i > speed_q) begin
                speed_d = (up_sum >= {1'b0, target_i}) ? target_i : up_sum[7:0];
            end else if (target_i < speed_q) begin
                speed_d = (dn_diff[8] || (dn_diff[7:0] <= target_i)) ? target_i : dn_diff[7:0];
            end
        end
    end

    // Prescaler and speed registers; reset aborts any ramp in progress.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            presc_q <= '0;
            speed_q <= 8'd0;
        end else begin
            presc_q <= presc_d;
            speed_q <= speed_d;
        end
    end

    assign speed_o = speed_q;

endmodule

// File: rtl/chs_thermostat_ctrl.sv
// Closed-loop thermostat controller: hysteresis, per-state dwell, forced
// ramp-down changeover through DEAD, and the chs_conf degree mux.
module chs_thermostat_ctrl
    import chs_thermostat_ctrl_pkg::*;
#(
    parameter int unsigned HYST     = DefHyst,
    parameter int unsigned DWELL    = DefDwell,
    parameter int unsigned RAMP_DIV = DefRampDiv,
    parameter int unsigned STEP     = DefStep,
    parameter int unsigned GAIN_SH  = DefGainSh
) (
    input logic                  clk,
    input logic                  arst,
    chs_thermostat_ctrl_if.slave bus_io
);

    localparam int unsigned   DW       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DwellMax = DW'(DWELL - 1);
    localparam logic [8:0]    Hyst9    = 9'(HYST);

    chs_state_e    state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [7:0]    t_q, sp_q;
    logic [7:0]    chs_conf_q, chs_conf_d;
    logic          sample_err_q, sample_err_d;
    logic          dwell_exp;
    logic          active;
    logic [8:0]    sp9, lo9, hi9;
    logic [8:0]    temp9;
    logic [7:0]    target;
    logic [7:0]    speed;

    // Thresholds come from the incoming setpoint, since transitions are judged
    // against the sample arriving this cycle rather than the latched one.
    always_comb begin
        sp9   = {1'b0, bus_io.setpoint};
        temp9 = {1'b0, bus_io.temp};
        lo9   = (sp9 >= Hyst9) ? (sp9 - Hyst9) : 9'd0;
        hi9   = ((sp9 + Hyst9) > 9'd255) ? 9'd255 : (sp9 + Hyst9);
    end

    // Next-state logic; enable low drags HEAT/COOL to DEAD regardless of dwell.
    always_comb begin
        state_d   = state_q;
        dwell_exp = (dwell_q == '0);
        unique case (state_q)
            StIdle: begin
                if (bus_io.enable && bus_io.temp_vld && dwell_exp) begin
                    if (temp9 < lo9) begin
                        state_d = StHeat;
                    end else if (temp9 > hi9) begin
                        state_d = StCool;
                    end
                end
            end
            StHeat: begin
                if (!bus_io.enable) begin
                    state_d = StDead;
                end else if (bus_io.temp_vld && dwell_exp &&
                             (bus_io.temp >= bus_io.setpoint)) begin
                    state_d = StDead;
                end
            end
            StCool: begin
                if (!bus_io.enable) begin
                    state_d = StDead;
                end else if (bus_io.temp_vld && dwell_exp &&
                             (bus_io.temp <= bus_io.setpoint)) begin
                    state_d = StDead;
                end
            end
            StDead: begin
                if ((speed == 8'd0) && dwell_exp) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Dwell reloads on every state change, otherwise counts down and sticks at 0.
    always_comb begin
        dwell_d = dwell_q;
        if (state_d != state_q) begin
            dwell_d = DwellMax;
        end else if (dwell_q != '0) begin
            dwell_d = dwell_q - DW'(1);
        end
    end

    // Target speed, the chs_conf mux (idle shows zero error) and the rail flag.
    always_comb begin
        active       = (state_q == StHeat) || (state_q == StCool);
        target       = active ? sat_shl(abs_diff(t_q, sp_q), GAIN_SH) : 8'd0;
        chs_conf_d   = active ? t_q : sp_q;
        sample_err_d = bus_io.temp_vld && ((bus_io.temp == 8'd0) || (bus_io.temp == 8'hff));
    end

    // State, dwell, sample latches and registered outputs.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= StIdle;
            dwell_q      <= DwellMax;
            t_q          <= 8'd0;
            sp_q         <= 8'd0;
            chs_conf_q   <= 8'd0;
            sample_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dwell_q      <= dwell_d;
            chs_conf_q   <= chs_conf_d;
            sample_err_q <= sample_err_d;
            if (bus_io.temp_vld) begin
                t_q  <= bus_io.temp;
                sp_q <= bus_io.setpoint;
            end
        end
    end

    chs_thermostat_ctrl_speed_ramp #(
        .RAMP_DIV (RAMP_DIV),
        .STEP     (STEP)
    ) u_speed_ramp (
        .clk      (clk),
        .arst     (arst),
        .target_i (target),
        .speed_o  (speed)
    );

    assign bus_io.speed      = speed;
    assign bus_io.chs_conf   = chs_conf_q;
    assign bus_io.state      = state_q;
    assign bus_io.sample_err = sample_err_q;

endmodule

// File: tb/tb_chs_thermostat_ctrl.sv
// Directed bench for chs_thermostat_ctrl with default parameters. Inputs change
// and outputs are sampled on the falling edge; edge numbers in comments count
// rising edges since reset release.
module tb_chs_thermostat_ctrl;

    logic clk = 1'b0;
    logic arst;

    int n_vec = 0;
    int n_err = 0;

    chs_thermostat_ctrl_if bus();

    chs_thermostat_ctrl u_dut (
        .clk    (clk),
        .arst   (arst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic [7:0] t, input logic [7:0] sp);
        bus.temp     = t;
        bus.setpoint = sp;
        bus.temp_vld = 1'b1;
        step(1);
        bus.temp_vld = 1'b0;
    endtask

    initial begin
        int   trans;
        int   hops;
        int   min_gap;
        int   last_i;
        int   waited;
        logic [1:0] prev;

        arst         = 1'b1;
        bus.enable   = 1'b1;
        bus.temp     = 8'd0;
        bus.temp_vld = 1'b0;
        bus.setpoint = 8'd25;
        step(2);
        check_eq("rst_state", bus.state, 0);
        check_eq("rst_speed", bus.speed, 0);
        check_eq("rst_conf", bus.chs_conf, 0);
        check_eq("rst_serr", bus.sample_err, 0);
        arst = 1'b0;

        // Heat entry once the reset dwell has run out.
        step(15);
        strobe(8'd20, 8'd25);                       // edge 16
        check_eq("heat_entry", bus.state, 1);
        check_eq("heat_spd0", bus.speed, 0);
        step(1);                                    // edge 17
        check_eq("heat_conf", bus.chs_conf, 20);
        step(3);                                    // edge 20
        check_eq("ramp_8", bus.speed, 8);
        for (int k = 2; k <= 5; k++) begin
            step(4);
            check_eq("ramp_up", bus.speed, 8 * k);
        end
        step(8);                                    // edge 44
        check_eq("ramp_hold40", bus.speed, 40);

        // Reaching setpoint: HEAT -> DEAD, ramp down, then IDLE.
        strobe(8'd25, 8'd25);                       // edge 45
        check_eq("heat_to_dead", bus.state, 3);
        step(1);
        check_eq("dead_conf", bus.chs_conf, 25);
        step(2);                                    // edge 48
        check_eq("ramp_dn32", bus.speed, 32);
        step(16);                                   // edge 64
        check_eq("ramp_dn0", bus.speed, 0);
        check_eq("dead_hold", bus.state, 3);
        step(1);                                    // edge 65
        check_eq("dead_to_idle", bus.state, 0);
        step(1);
        check_eq("idle_conf", bus.chs_conf, 25);

        // Rail sample with lo saturating to 0: no heat, one error pulse.
        step(14);
        strobe(8'd0, 8'd1);                         // edge 81
        check_eq("lo_sat_idle", bus.state, 0);
        check_eq("serr_pulse", bus.sample_err, 1);
        step(1);
        check_eq("serr_clear", bus.sample_err, 0);
        check_eq("idle_conf_sp1", bus.chs_conf, 1);

        // Cool entry, then enable drop during dwell.
        strobe(8'd40, 8'd20);                       // edge 83
        check_eq("cool_entry", bus.state, 2);
        step(1);                                    // edge 84
        check_eq("cool_conf", bus.chs_conf, 40);
        check_eq("cool_spd8", bus.speed, 8);
        step(2);
        bus.enable = 1'b0;
        step(1);                                    // edge 87
        check_eq("en_off_dead", bus.state, 3);
        check_eq("en_off_spd", bus.speed, 8);
        step(1);                                    // edge 88
        check_eq("en_off_spd0", bus.speed, 0);
        check_eq("en_off_conf", bus.chs_conf, 20);
        step(1);
        strobe(8'd10, 8'd20);                       // edge 90, cold sample in DEAD
        check_eq("dead_cold", bus.state, 3);
        step(12);                                   // edge 102
        check_eq("dead_dwell", bus.state, 3);
        step(1);                                    // edge 103
        check_eq("dead_idle2", bus.state, 0);
        step(16);
        strobe(8'd10, 8'd20);                       // edge 120, enable still low
        check_eq("idle_disabled", bus.state, 0);
        step(1);
        check_eq("idle_conf20", bus.chs_conf, 20);

        // Alternating samples every cycle.
        bus.enable = 1'b1;
        trans   = 0;
        hops    = 0;
        min_gap = 1000;
        last_i  = -1000;
        prev    = bus.state;
        for (int i = 0; i < 200; i++) begin
            bus.temp     = (i % 2 == 0) ? 8'd10 : 8'd40;
            bus.setpoint = 8'd25;
            bus.temp_vld = 1'b1;
            step(1);
            if (bus.state != prev) begin
                trans++;
                if (i - last_i < min_gap) min_gap = i - last_i;
                last_i = i;
                if ((prev == 2'd1 && bus.state == 2'd2) || (prev == 2'd2 && bus.state == 2'd1))
                    hops++;
            end
            prev = bus.state;
        end
        bus.temp_vld = 1'b0;
        check_eq("alt_no_hop", hops, 0);
        check_eq("alt_gap_ge_dwell", (min_gap >= 16), 1);
        check_eq("alt_active", (trans >= 3), 1);

        // Asynchronous reset in the middle of a ramp.
        arst = 1'b1;
        step(2);
        arst = 1'b0;
        step(15);
        strobe(8'd10, 8'd25);                       // edge 16, target 120
        check_eq("heat2_entry", bus.state, 1);
        waited = 0;
        while (bus.speed != 8'd96 && waited < 200) begin
            step(1);
            waited++;
        end
        check_eq("pre_rst_speed", bus.speed, 96);
        check_eq("pre_rst_conf", bus.chs_conf, 10);
        #2 arst = 1'b1;
        #1;
        check_eq("arst_state", bus.state, 0);
        check_eq("arst_speed", bus.speed, 0);
        check_eq("arst_conf", bus.chs_conf, 0);
        check_eq("arst_serr", bus.sample_err, 0);
        step(1);
        arst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/chs_thermostat_ctrl.md
# chs_thermostat_ctrl

Closed-loop thermostat controller that sequences the cool/heat system. It turns periodic temperature samples and a user setpoint into the `speed` duty-cycle and `chs_conf` degree inputs of the cool/heat datapath. It enforces hysteresis, minimum dwell per mode, a mandatory ramp-down changeover between heating and cooling, and a rate-limited fan-speed ramp. It sits between the sensor/user-register interface and the cool/heat system instance.

## Interface
Parameters:
- `HYST`, 2: hysteresis band in degrees, 0..15.
- `DWELL`, 16: minimum cycles spent in any state before a sample-driven exit, ≥1.
- `RAMP_DIV`, 4: cycles per speed-ramp step, ≥1.
- `STEP`, 8: speed increment/decrement per ramp step, 1..255.
- `GAIN_SH`, 3: left-shift applied to the error to form the target speed, 0..7.

Ports:
- `clk`, in, 1: clock; all state changes on the posedge.
- `arst`, in, 1: reset; asynchronous, active-high.
- `enable`, in, 1: system on; low forces shutdown sequencing.
- `temp`, in, 8: measured temperature, unsigned degrees.
- `temp_vld`, in, 1: one-cycle strobe qualifying `temp`.
- `setpoint`, in, 8: target temperature, unsigned degrees; sampled together with `temp`.
- `speed`, out, 8: duty-cycle to the fan PWM; registered.
- `chs_conf`, out, 8: degree configuration to the mode/power decoder; registered.
- `state`, out, 2: current state, encoded IDLE=0, HEAT=1, COOL=2, DEAD=3.
- `sample_err`, out, 1: registered pulse raised when `temp_vld` arrives while `temp` is 0 or 255 (sensor rail); the sample is still used.

## Operation
- On `temp_vld`, latch `temp`→`t_q` and `setpoint`→`sp_q`.
- Compute `lo = max(sp_q − HYST, 0)` and `hi = min(sp_q + HYST, 255)` in 9-bit arithmetic with saturation.
- `err = |t_q − sp_q|`, 8-bit.
- `target = min(err << GAIN_SH, 255)` in HEAT and COOL; `target = 0` in IDLE and DEAD.
- Dwell counter: reloads `DWELL−1` on every state entry and on reset, decrements to 0, then holds. "Expired" means the counter is 0.
- Transitions are evaluated on a cycle with `temp_vld`=1, using the incoming `temp`/`setpoint` values, and require the dwell counter to be expired:
  - IDLE→HEAT if `temp < lo`.
  - IDLE→COOL if `temp > hi`.
  - HEAT→DEAD if `temp ≥ setpoint`.
  - COOL→DEAD if `temp ≤ setpoint`.
- DEAD→IDLE when `speed == 0` and the dwell counter is expired; no sample is needed.
- `enable`=0:
  - HEAT or COOL go to DEAD immediately, ignoring dwell.
  - IDLE stays IDLE.
  - DEAD proceeds normally.
- HEAT↔COOL never transition directly; the path always runs through DEAD and IDLE.
- `chs_conf` is `t_q` in HEAT/COOL and `sp_q` in IDLE/DEAD, so the decoder sees zero error while idle.
- Speed ramp:
  - A free-running prescaler counts 0..RAMP_DIV−1.
  - On wrap, `speed` moves toward `target` by `STEP`, clamped to land exactly on `target`, with no overshoot or wrap.
  - Otherwise `speed` holds.

## Timing
- Reset values: `state`=IDLE, `speed`=0, `chs_conf`=0, `sample_err`=0, `t_q`=`sp_q`=0, prescaler=0, dwell=`DWELL−1`.
- Reset mid-operation aborts any ramp immediately.
- A strobe at edge N updates `state`, `t_q`, `sp_q` and `sample_err` at edge N.
- `chs_conf` reflects the new state/latches at edge N+1 (one cycle latency).
- `speed` changes only on prescaler wrap edges. Worst-case ramp 0→255 takes ceil(255/STEP)·RAMP_DIV cycles.
- Simultaneous events:
  - A strobe with an unexpired dwell still updates the latches, but no transition occurs.
  - `enable` falling and a strobe in the same cycle: the enable rule wins.
  - A strobe in DEAD updates the latches only.
- Back-to-back strobes are legal every cycle.

## Structure
- Shared include `chs_defs.vh`: state encodings and default parameter values, reused by the cool/heat system's test harness.
- Sub-module `SpeedRamp`: owns the prescaler and the saturating step-toward-target logic. Inputs are `target` and `clk`/`arst`; output is `speed`.
- The FSM, dwell counter, latches and the `chs_conf` mux stay in the top module.

## Test plan
- Reset with `setpoint`=25, then strobe `temp`=20 after dwell expires → `state`=HEAT at the strobe edge; `speed` ramps 0→8→16→…→40 (err 5<<3) every 4 cycles and stops at 40; `chs_conf`=20.
- In HEAT, strobe `temp`=25 → DEAD; `speed` steps down to 0; then IDLE after DWELL; `chs_conf`=25.
- `setpoint`=1, `HYST`=2, strobe `temp`=0 → `lo` saturates to 0, no HEAT entry, `sample_err` pulses once.
- In COOL with `temp`=40, `setpoint`=20 (target 160): deassert `enable` during dwell → DEAD on the next edge, `speed` ramps down to 0, then IDLE. HEAT is never entered even if a cold sample arrives during DEAD.
- Strobe every cycle alternating `temp`=10 and 40 with `setpoint`=25 → exactly one transition per DWELL window, no HEAT↔COOL direct transition, `speed` never exceeds 255.
- Assert `arst` mid-ramp at `speed`=96 → all outputs are at reset values within the same cycle, asynchronously.
